// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and the 1-bit full-adder helper used to build the ripple chain.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_adder_ci.sv
// 4-bit ripple-carry adder with carry-in. Also exposes the carry into bit 3,
// which the top level needs to derive signed overflow of the most
// significant nibble.
module nibble_adder_ci
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co,
    output logic             c3
);

    logic [NIB_W:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign {carry_s[i+1], s[i]} = full_add(a[i], b[i], carry_s[i]);
    end

    assign co = carry_s[NIB_W];
    assign c3 = carry_s[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder. Operands are accepted in IDLE, one nibble per
// clock is summed in RUN with a registered carry between nibbles, and the
// result is held in DONE until the consumer takes it.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] nib_cnt_q;
    logic             cout_q;
    logic             ovf_q;

    logic [NIB_W-1:0] nib_sum_s;
    logic             nib_co_s;
    logic             nib_c3_s;

    // The only carry chain in the design: low nibble of each shifter.
    nibble_adder_ci u_nib (
        .a  (a_sh_q[NIB_W-1:0]),
        .b  (b_sh_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (nib_sum_s),
        .co (nib_co_s),
        .c3 (nib_c3_s)
    );

    // Control FSM together with the operand/result shifters and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            nib_cnt_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_q    <= a;
                        b_sh_q    <= b;
                        carry_q   <= cin;
                        nib_cnt_q <= '0;
                        state_q   <= ST_RUN;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Nibble results enter from the top so that after NIBBLES
                    // shifts nibble 0 has reached the bottom of the register.
                    sum_sh_q  <= {nib_sum_s, sum_sh_q[WIDTH-1:NIB_W]};
                    a_sh_q    <= {{NIB_W{1'b0}}, a_sh_q[WIDTH-1:NIB_W]};
                    b_sh_q    <= {{NIB_W{1'b0}}, b_sh_q[WIDTH-1:NIB_W]};
                    carry_q   <= nib_co_s;
                    nib_cnt_q <= nib_cnt_q + CNT_W'(1);
                    if (nib_cnt_q == LAST_NIB) begin
                        // Most significant nibble: its carries define the flags.
                        cout_q  <= nib_co_s;
                        ovf_q   <= nib_co_s ^ nib_c3_s;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags come from the state register only; in_ready is also
    // held low while reset is asserted.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_sh_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that feeds a 4-bit ripple-carry nibble adder one nibble per clock and consumes its sum and carry-out. A registered carry links successive nibbles. Sits in front of wide datapath consumers that need WIDTH-bit sums without a WIDTH-bit carry chain. Operands enter through a valid/ready handshake; the result leaves through another valid/ready handshake with carry-out and signed overflow.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8
- NIBBLES, WIDTH/4, derived localparam, not overridable
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and cin valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in to nibble 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into shift registers, carry_reg<=cin, nib_cnt<=0, go to RUN.
- RUN, each cycle:
  - The nibble adder takes a_sh[3:0], b_sh[3:0], carry_reg.
  - Its 4-bit sum shifts into sum_sh from the top, i.e. sum_sh <= {nib_sum, sum_sh[WIDTH-1:4]}.
  - a_sh and b_sh shift right by 4.
  - carry_reg <= nibble carry-out.
  - nib_cnt increments.
- RUN exit: on the cycle with nib_cnt==NIBBLES-1, latch cout <= nibble carry-out and ovf <= nibble carry-out XOR carry into bit 3 of that nibble, then go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout, ovf hold stable until out_valid&&out_ready, then go to IDLE.
- in_ready=0 in RUN and DONE; in_valid is ignored there, and a, b, cin are don't-care outside the accept cycle.
- No accept in the same cycle as the result handshake; the next accept happens in IDLE at the earliest.
- Arithmetic: unsigned modulo 2^WIDTH. ovf is meaningful under a two's-complement interpretation; cout under an unsigned one.

## Timing
- Reset, applied synchronously:
  - state=IDLE, out_valid=0, busy=0, sum=0, cout=0, ovf=0, carry_reg=0, nib_cnt=0.
  - in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Latency: for an accept at edge t, out_valid is high after edge t+NIBBLES (4 cycles for WIDTH=16).
- Throughput with out_ready tied high: one operation per NIBBLES+2 cycles (RUN × NIBBLES, DONE, IDLE).
- Backpressure: DONE persists indefinitely; outputs do not change.
- Reset mid-RUN or in DONE:
  - The operation is abandoned and out_valid=0 the cycle after the reset edge.
  - No partial result is ever presented.
- in_ready, out_valid and busy are decoded from state registers only; they have no combinational path from in_valid or out_ready.
- Worst-case combinational path is one 4-bit ripple chain plus register setup.

## Structure
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NIB_W=4.
- Sub-module nibble_adder_ci: 4-bit ripple-carry adder with carry-in.
  - Ports: a[3:0], b[3:0], ci, s[3:0], co, c3 (carry into bit 3).
  - Built from 1-bit full adders.
- Top level contains the FSM, shift registers, nib_cnt ($clog2(NIBBLES) bits), carry_reg and output registers.

## Test plan
- WIDTH=16, a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0; out_valid first high exactly 4 cycles after the accept edge; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0; confirms the carry ripples across all nibble boundaries.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 with new operands.
  - sum, cout, ovf stable; in_ready=0; new operands not captured.
  - On out_ready=1: handshake, IDLE next cycle, in_ready=1.
- Assert rst for one cycle during the 2nd RUN cycle.
  - Next cycle: out_valid=0, busy=0, sum=0.
  - in_ready=1 after rst falls.
  - A fresh a=0x1234, b=0x4321 yields 0x5555.
- Random regression: 1000 operations with random out_ready stalls, WIDTH=16 and WIDTH=8; every result matches a+b+cin for sum and cout, and the signed-overflow model for ovf.
